// File: rtl/avg_pool_drain.sv
// Buffers LANES-wide result vectors from avg_pool and drains them one lane per beat
// onto a valid/ready word stream; vectors arriving with no free slot are dropped and flagged.
module avg_pool_drain #(
    parameter int LANES = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16,
    localparam int LW   = (LANES > 1) ? $clog2(LANES) : 1,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int OW   = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                init,
    input  logic [LANES*DW-1:0] in_vec,
    input  logic                in_vec_valid,
    output logic [DW-1:0]       m_data,
    output logic [LW-1:0]       m_lane,
    output logic                m_last,
    output logic                m_valid,
    input  logic                m_ready,
    output logic                full,
    output logic                overflow,
    output logic [CNT_W-1:0]    vec_count
);

    typedef enum logic {ST_IDLE, ST_STREAM} state_t;

    state_t              state_q, state_d;
    logic [LANES*DW-1:0] mem_q [DEPTH];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]       occ_q, occ_d;
    logic [LW-1:0]       lane_q, lane_d;
    logic                overflow_q, overflow_d;
    logic [CNT_W-1:0]    vec_count_q, vec_count_d;

    logic on_last, hs, pop, wr_en, drop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (occ_q == OW'(DEPTH));
    assign m_valid = (state_q == ST_STREAM);
    assign on_last = (lane_q == LW'(LANES - 1));
    assign hs      = m_valid && m_ready;
    assign pop     = hs && on_last;
    // A slot freed by this cycle's final-lane pop can take the incoming vector.
    assign wr_en   = in_vec_valid && (!full || pop);
    assign drop    = in_vec_valid && full && !pop;

    assign m_data  = m_valid ? mem_q[rd_ptr_q][lane_q*DW +: DW] : '0;
    assign m_lane  = m_valid ? lane_q : '0;
    assign m_last  = m_valid && on_last;
    assign overflow  = overflow_q;
    assign vec_count = vec_count_q;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path infers a latch.
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        lane_d      = lane_q;
        overflow_d  = overflow_q;
        vec_count_d = vec_count_q;

        if (hs) begin
            lane_d = on_last ? '0 : lane_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d    = ptr_inc(rd_ptr_q);
            vec_count_d = vec_count_q + 1'b1;
        end
        if (wr_en) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (wr_en && !pop) begin
            occ_d = occ_q + 1'b1;
        end else if (pop && !wr_en) begin
            occ_d = occ_q - 1'b1;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end

        case (state_q)
            ST_IDLE:   if (wr_en) state_d = ST_STREAM;
            ST_STREAM: if (pop && !wr_en && occ_q == OW'(1)) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments for all state so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || init) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            lane_q      <= '0;
            overflow_q  <= 1'b0;
            vec_count_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            lane_q      <= lane_d;
            overflow_q  <= overflow_d;
            vec_count_q <= vec_count_d;
        end
    end

    // NOTE: slot storage is not reset; occupancy gates every read, so stale data is never visible.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= in_vec;
        end
    end

endmodule

// File: tb/tb_avg_pool_drain.sv
// Scoreboard bench for avg_pool_drain: stimulus pushes expected beats, a negedge monitor
// pops and compares each handshake and checks stall stability.
module tb_avg_pool_drain;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, init;
    logic [1023:0] in_vec;
    logic          in_vec_valid;
    logic [31:0]   m_data;
    logic [4:0]    m_lane;
    logic          m_last, m_valid, m_ready, full, overflow;
    logic [15:0]   vec_count;

    logic [31:0]   in_vec4;
    logic          in_valid4, ready4;
    logic [7:0]    m_data4;
    logic [1:0]    m_lane4;
    logic          m_last4, m_valid4, full4, overflow4;
    logic [3:0]    vec_count4;

    avg_pool_drain dut (
        .clk(clk), .rst(rst), .init(init),
        .in_vec(in_vec), .in_vec_valid(in_vec_valid),
        .m_data(m_data), .m_lane(m_lane), .m_last(m_last),
        .m_valid(m_valid), .m_ready(m_ready),
        .full(full), .overflow(overflow), .vec_count(vec_count)
    );

    avg_pool_drain #(.LANES(4), .DW(8), .DEPTH(2), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .init(init),
        .in_vec(in_vec4), .in_vec_valid(in_valid4),
        .m_data(m_data4), .m_lane(m_lane4), .m_last(m_last4),
        .m_valid(m_valid4), .m_ready(ready4),
        .full(full4), .overflow(overflow4), .vec_count(vec_count4)
    );

    typedef struct packed {
        logic [31:0] d;
        logic [4:0]  l;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;
    int    beats    = 0;
    bit    toggle   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_vec(input logic [31:0] base);
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back('{d: base + i, l: 5'(i), last: (i == 31)});
        end
    endtask

    task automatic send_vec(input logic [31:0] base);
        for (int i = 0; i < 32; i++) in_vec[i*32 +: 32] = base + i;
        in_vec_valid = 1'b1;
        tick();
        in_vec_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        in_vec_valid = 1'b0;
        in_valid4    = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
        beats = 0;
    endtask

    task automatic wait_drain(input int budget);
        for (int c = 0; c < budget && exp_q.size() != 0; c++) begin
            if (toggle) m_ready = ~m_ready;
            tick();
        end
        check("drain_done_remaining", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_lane(input logic [4:0] lane);
        for (int c = 0; c < 200 && !(m_valid && m_lane == lane); c++) tick();
        check("reach_lane", {m_valid, 3'b0, m_lane}, {1'b1, 3'b0, lane});
    endtask

    // Monitor: pop on every handshake, verify the head is held while stalled.
    always @(negedge clk) begin : monitor
        beat_t e;
        if (!rst && !init && m_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat: got lane %0d data 0x%0h, expected no output", m_lane, m_data);
            end else if (m_ready) begin
                e = exp_q.pop_front();
                check("beat_data", 64'(m_data), 64'(e.d));
                check("beat_lane", 64'(m_lane), 64'(e.l));
                check("beat_last", 64'(m_last), 64'(e.last));
                beats++;
            end else begin
                e = exp_q[0];
                check("hold_data", 64'(m_data), 64'(e.d));
                check("hold_lane", 64'(m_lane), 64'(e.l));
            end
        end
    end

    task automatic test_clear(input bit use_init);
        do_reset();
        m_ready = 1'b0;
        push_vec(32'h500); send_vec(32'h500);
        tick();
        push_vec(32'h600); send_vec(32'h600);
        tick();
        send_vec(32'h700);
        check("t5_overflow_before", 64'(overflow), 64'd1);
        m_ready = 1'b1;
        wait_lane(5'd10);
        if (use_init) init = 1'b1; else rst = 1'b1;
        tick();
        init = 1'b0;
        rst  = 1'b0;
        exp_q.delete();
        check("t5_valid", 64'(m_valid), 64'd0);
        check("t5_count", 64'(vec_count), 64'd0);
        check("t5_overflow", 64'(overflow), 64'd0);
        check("t5_full", 64'(full), 64'd0);
        check("t5_data", 64'(m_data), 64'd0);
        check("t5_lane", 64'(m_lane), 64'd0);
        repeat (3) tick();
        check("t5_stays_idle", 64'(m_valid), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; init = 1'b0; in_vec = '0; in_vec_valid = 1'b0; m_ready = 1'b0;
        in_vec4 = '0; in_valid4 = 1'b0; ready4 = 1'b1;
        do_reset();

        // Reset state
        check("rst_valid", 64'(m_valid), 64'd0);
        check("rst_data", 64'(m_data), 64'd0);
        check("rst_lane", 64'(m_lane), 64'd0);
        check("rst_last", 64'(m_last), 64'd0);
        check("rst_full", 64'(full), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_count", 64'(vec_count), 64'd0);

        // 1: single vector, always ready
        m_ready = 1'b1;
        push_vec(32'h100);
        send_vec(32'h100);
        check("t1_latency_valid", 64'(m_valid), 64'd1);
        check("t1_latency_lane", 64'(m_lane), 64'd0);
        check("t1_latency_data", 64'(m_data), 64'h100);
        wait_drain(100);
        check("t1_beats", 64'(beats), 64'd32);
        check("t1_count", 64'(vec_count), 64'd1);
        check("t1_idle", 64'(m_valid), 64'd0);

        // 2: toggling ready
        do_reset();
        m_ready = 1'b0;
        toggle  = 1'b1;
        push_vec(32'h100);
        send_vec(32'h100);
        wait_drain(200);
        toggle = 1'b0;
        check("t2_beats", 64'(beats), 64'd32);
        check("t2_overflow", 64'(overflow), 64'd0);
        check("t2_count", 64'(vec_count), 64'd1);

        // 3: burst of three with ready low, third dropped
        do_reset();
        m_ready = 1'b0;
        push_vec(32'h200); send_vec(32'h200);
        check("t3_full_after1", 64'(full), 64'd0);
        tick();
        push_vec(32'h300); send_vec(32'h300);
        check("t3_full_after2", 64'(full), 64'd1);
        tick();
        send_vec(32'h400);
        check("t3_overflow", 64'(overflow), 64'd1);
        check("t3_full_after3", 64'(full), 64'd1);
        m_ready = 1'b1;
        wait_drain(300);
        repeat (3) tick();
        check("t3_beats", 64'(beats), 64'd64);
        check("t3_count", 64'(vec_count), 64'd2);
        check("t3_overflow_sticky", 64'(overflow), 64'd1);
        check("t3_full_end", 64'(full), 64'd0);

        // 4: write into the slot freed by a same-cycle pop
        do_reset();
        m_ready = 1'b0;
        push_vec(32'h800); send_vec(32'h800);
        push_vec(32'h900); send_vec(32'h900);
        check("t4_full", 64'(full), 64'd1);
        m_ready = 1'b1;
        wait_lane(5'd31);
        push_vec(32'hA00);
        send_vec(32'hA00);
        check("t4_full_kept", 64'(full), 64'd1);
        check("t4_overflow", 64'(overflow), 64'd0);
        wait_drain(300);
        check("t4_beats", 64'(beats), 64'd96);
        check("t4_count", 64'(vec_count), 64'd3);
        check("t4_overflow_end", 64'(overflow), 64'd0);

        // 5: init then rst mid-stream
        test_clear(1'b1);
        test_clear(1'b0);

        // 6: narrow counter wraps after 16 vectors
        do_reset();
        for (int v = 0; v < 17; v++) begin
            in_vec4   = {4{8'(v)}};
            in_valid4 = 1'b1;
            tick();
            in_valid4 = 1'b0;
            repeat (3) tick();
        end
        repeat (8) tick();
        check("t6_count_wrap", 64'(vec_count4), 64'd1);
        check("t6_overflow", 64'(overflow4), 64'd0);
        check("t6_idle", 64'(m_valid4), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
